// File: rtl/spi_cfg_pkg.sv
// Shared types and defaults for the SPI configuration sequencer.
// One-hot FSM encoding follows the downstream shift engine's style.
package spi_cfg_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_NUM_WORDS      = 16;
    localparam int DEF_GAP_CYCLES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    localparam int ST_W = 8;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE      = 8'b0000_0001,
        ST_LOAD      = 8'b0000_0010,
        ST_REQ       = 8'b0000_0100,
        ST_WAIT_BUSY = 8'b0000_1000,
        ST_WAIT_DONE = 8'b0001_0000,
        ST_GAP       = 8'b0010_0000,
        ST_DONE      = 8'b0100_0000,
        ST_ERR       = 8'b1000_0000
    } state_e;

endpackage

// File: rtl/spi_cfg_table.sv
// Command-word register file: one synchronous write port, one registered read port.
module spi_cfg_table
    import spi_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WORDS  = DEF_NUM_WORDS
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [$clog2(NUM_WORDS)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic                         rd_en_i,
    input  logic [$clog2(NUM_WORDS)-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]        rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] rd_q;

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Streams a table of command words into the SPI engine with inter-frame gaps.
// Optional stalled-engine watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_cfg_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_WORDS      = DEF_NUM_WORDS,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         cfg_wr_i,
    input  logic [$clog2(NUM_WORDS)-1:0] cfg_addr_i,
    input  logic [DATA_WIDTH-1:0]        cfg_data_i,
    input  logic [$clog2(NUM_WORDS):0]   len_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    output logic [DATA_WIDTH-1:0]        sdo_data_o,
    output logic                         sdo_valid_o,
    input  logic                         sdo_ready_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [$clog2(NUM_WORDS)-1:0] word_idx_o
);

    localparam int AW = $clog2(NUM_WORDS);
    localparam int LW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LW-1:0] LEN_MAX  = LW'(NUM_WORDS);

    state_e          state_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   len_d;
    logic [AW-1:0]   idx_q;
    logic [GW-1:0]   gap_q;
    logic            abort_q;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;
    logic            last_w;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_q;
    logic          err_q;
    logic          to_hit;
    assign to_hit = (to_cnt_q == TO_LAST);
`endif

    assign len_d  = (len_i > LEN_MAX) ? LEN_MAX : len_i;
    assign last_w = ({1'b0, idx_q} == (len_q - LW'(1)));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            abort_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            to_cnt_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q   <= len_d;
                        idx_q   <= '0;
                        abort_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        if (len_d == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_REQ;
                        valid_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    abort_q <= abort_q | abort_i;
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    abort_q <= abort_q | abort_i;
                    if (sdo_ready_i) begin
                        state_q <= ST_WAIT_DONE;
`ifdef SPI_SEQ_TIMEOUT_EN
                    end else if (to_hit) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
`endif
                    end
                end
                ST_WAIT_DONE: begin
                    abort_q <= abort_q | abort_i;
                    // A pending abort only takes effect once the frame has ended.
                    if (!sdo_ready_i) begin
                        if (abort_q || abort_i) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else if (last_w) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + AW'(1);
                            gap_q   <= '0;
                            state_q <= (GAP_CYCLES == 0) ? ST_LOAD : ST_GAP;
                        end
`ifdef SPI_SEQ_TIMEOUT_EN
                    end else if (to_hit) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
`endif
                    end
                end
                ST_GAP: begin
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (gap_q == GAP_LAST) begin
                        state_q <= ST_LOAD;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
`ifdef SPI_SEQ_TIMEOUT_EN
                ST_ERR: begin
                    state_q <= ST_IDLE;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    spi_cfg_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) u_table (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .wr_en_i   (cfg_wr_i & ~busy_q),
        .wr_addr_i (cfg_addr_i),
        .wr_data_i (cfg_data_i),
        .rd_en_i   (state_q == ST_LOAD),
        .rd_addr_i (idx_q),
        .rd_data_o (sdo_data_o)
    );

    assign sdo_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign word_idx_o  = idx_q;

`ifdef SPI_SEQ_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Randomized bench for spi_cfg_sequencer against a timing/data reference model.
module tb_spi_cfg_sequencer;

    localparam int DW  = 32;
    localparam int NW  = 16;
    localparam int AW  = 4;
    localparam int LW  = 5;
    localparam int GAP = 4;
    localparam int TO  = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_wr = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic [LW-1:0] len = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          sdo_ready = 1'b0;
    logic [DW-1:0] sdo_data;
    logic          sdo_valid;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] word_idx;

    spi_cfg_sequencer #(
        .DATA_WIDTH     (DW),
        .NUM_WORDS      (NW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk),
        .rst_n       (rst_n),
        .cfg_wr_i    (cfg_wr),
        .cfg_addr_i  (cfg_addr),
        .cfg_data_i  (cfg_data),
        .len_i       (len),
        .start_i     (start),
        .abort_i     (abort),
        .sdo_data_o  (sdo_data),
        .sdo_valid_o (sdo_valid),
        .sdo_ready_i (sdo_ready),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .word_idx_o  (word_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] tm [NW];
    logic [DW-1:0] vq_data [$];
    int            vq_cyc [$];
    int            done_cyc [$];
    int            fall_cyc [$];
    logic          prev_rdy = 1'b0;

    always @(negedge clk) begin
        if (sdo_valid) begin
            vq_data.push_back(sdo_data);
            vq_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (prev_rdy && !sdo_ready) fall_cyc.push_back(cyc);
        prev_rdy <= sdo_ready;
    end

    // Engine model: busy 2 cycles after the request, for eng_len cycles.
    int eng_len = 33;
    bit eng_en  = 1'b1;
    int e_dly   = 0;
    int e_run   = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            e_dly = 0;
            e_run = 0;
            sdo_ready = 1'b0;
        end else if (e_run > 0) begin
            e_run--;
            if (e_run == 0) sdo_ready = 1'b0;
        end else if (e_dly > 0) begin
            e_dly--;
            if (e_dly == 0) begin
                sdo_ready = 1'b1;
                e_run = eng_len;
            end
        end else if (sdo_valid && eng_en) begin
            e_dly = 2;
        end
    end

    task automatic clr_logs();
        vq_data.delete();
        vq_cyc.delete();
        done_cyc.delete();
        fall_cyc.delete();
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        cfg_wr = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = d;
        @(negedge clk);
        cfg_wr = 1'b0;
        tm[a] = d;
    endtask

    task automatic start_seq(input int l, output int t);
        @(negedge clk);
        clr_logs();
        len = LW'(l);
        start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rdy(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sdo_ready === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_stream(input int l, input string nm);
        int t, n, exp_c;
        bit ok;
        n = (l > NW) ? NW : l;
        start_seq(l, t);
        wait_idle(n * (eng_len + GAP + 8) + 10, ok);
        repeat (2) @(negedge clk);
        n_chk++;
        if (!ok) $display("FAIL %s idle_timeout: busy still %b", nm, busy);
        else n_pass++;
        n_chk++;
        if (vq_data.size() != n) $display("FAIL %s valid_count: got %0d exp %0d", nm, vq_data.size(), n);
        else n_pass++;
        n_chk++;
        if (done_cyc.size() != 1) $display("FAIL %s done_count: got %0d exp 1", nm, done_cyc.size());
        else n_pass++;
        n_chk++;
        if (fall_cyc.size() != n) $display("FAIL %s frame_count: got %0d exp %0d", nm, fall_cyc.size(), n);
        else n_pass++;
        if (vq_data.size() == n && fall_cyc.size() == n && done_cyc.size() == 1) begin
            for (int i = 0; i < n; i++) begin
                n_chk++;
                if (vq_data[i] !== tm[i]) $display("FAIL %s data[%0d]: got %h exp %h", nm, i, vq_data[i], tm[i]);
                else n_pass++;
                exp_c = (i == 0) ? t + 2 : fall_cyc[i-1] + 2 + GAP;
                n_chk++;
                if (vq_cyc[i] != exp_c) $display("FAIL %s valid_cyc[%0d]: got %0d exp %0d", nm, i, vq_cyc[i], exp_c);
                else n_pass++;
            end
            exp_c = (n == 0) ? t + 1 : fall_cyc[n-1] + 1;
            n_chk++;
            if (done_cyc[0] != exp_c) $display("FAIL %s done_cyc: got %0d exp %0d", nm, done_cyc[0], exp_c);
            else n_pass++;
        end
        n_chk++;
        if (word_idx !== AW'((n == 0) ? 0 : n - 1)) $display("FAIL %s word_idx: got %0d exp %0d", nm, word_idx, (n == 0) ? 0 : n - 1);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({sdo_valid, busy, done, err} !== 4'b0) $display("FAIL reset_flags: got %b exp 0000", {sdo_valid, busy, done, err});
        else n_pass++;
        n_chk++;
        if (sdo_data !== '0) $display("FAIL reset_data: got %h exp 0", sdo_data);
        else n_pass++;
        n_chk++;
        if (word_idx !== '0) $display("FAIL reset_idx: got %0d exp 0", word_idx);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b exp 0", busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        wr(0, 32'hA5A5_0001);
        wr(1, 32'hA5A5_0002);
        wr(2, 32'hA5A5_0003);
        eng_len = 33;
        test_stream(3, "basic");
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) wr(i, $urandom);
            eng_len = $urandom_range(1, 12);
            test_stream(n, "rand");
        end
    endtask

    task automatic test_len_bounds();
        for (int i = 0; i < NW; i++) wr(i, $urandom);
        eng_len = 3;
        test_stream(0, "len0");
        test_stream(20, "len20");
    endtask

    task automatic test_abort_mid();
        int t;
        bit ok;
        for (int i = 0; i < 4; i++) wr(i, $urandom);
        eng_len = 20;
        start_seq(4, t);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vq_data.size() == 2 && sdo_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_chk++;
        if (!ok) $display("FAIL abort_mid reach_word1: got %0d valids exp 2", vq_data.size());
        else n_pass++;
        wait_rdy(1'b0, 100, ok);
        n_chk++;
        if (!ok || busy !== 1'b1) $display("FAIL abort_mid frame_end: ok %b busy %b exp busy 1", ok, busy);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL abort_mid idle: got busy %b exp 0", busy);
        else n_pass++;
        repeat (40) @(negedge clk);
        n_chk++;
        if (vq_data.size() != 2 || done_cyc.size() != 0) $display("FAIL abort_mid counts: valids %0d dones %0d exp 2 0", vq_data.size(), done_cyc.size());
        else n_pass++;
        n_chk++;
        if (word_idx !== AW'(1)) $display("FAIL abort_mid word_idx: got %0d exp 1", word_idx);
        else n_pass++;
    endtask

    task automatic test_abort_gap();
        int t;
        bit ok1, ok2;
        eng_len = 5;
        start_seq(3, t);
        wait_rdy(1'b1, 50, ok1);
        wait_rdy(1'b0, 50, ok2);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_chk++;
        if (!ok1 || !ok2 || busy !== 1'b0) $display("FAIL abort_gap idle: ok %b%b busy %b exp busy 0", ok1, ok2, busy);
        else n_pass++;
        repeat (30) @(negedge clk);
        n_chk++;
        if (vq_data.size() != 1 || done_cyc.size() != 0) $display("FAIL abort_gap counts: valids %0d dones %0d exp 1 0", vq_data.size(), done_cyc.size());
        else n_pass++;
    endtask

    task automatic test_busy_lockout();
        int t;
        bit ok;
        logic [DW-1:0] a, b;
        a = $urandom;
        b = $urandom;
        wr(0, a);
        wr(1, b);
        eng_len = 8;
        start_seq(2, t);
        repeat (5) @(negedge clk);
        cfg_wr = 1'b1;
        cfg_addr = '0;
        cfg_data = ~a;
        start = 1'b1;
        len = LW'(1);
        @(negedge clk);
        cfg_wr = 1'b0;
        start = 1'b0;
        wait_idle(200, ok);
        repeat (2) @(negedge clk);
        n_chk++;
        if (!ok || vq_data.size() != 2 || done_cyc.size() != 1) $display("FAIL lockout seq: ok %b valids %0d dones %0d exp 1 2 1", ok, vq_data.size(), done_cyc.size());
        else n_pass++;
        n_chk++;
        if (vq_data.size() == 2 && (vq_data[0] !== a || vq_data[1] !== b)) $display("FAIL lockout data: got %h %h exp %h %h", vq_data[0], vq_data[1], a, b);
        else n_pass++;
        test_stream(1, "lockout_reread");
    endtask

    task automatic test_reset_mid();
        int t;
        bit ok1, ok2;
        for (int i = 0; i < 3; i++) wr(i, 32'h1000_0000 | $urandom);
        eng_len = 5;
        start_seq(3, t);
        wait_rdy(1'b1, 50, ok1);
        wait_rdy(1'b0, 50, ok2);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (!ok1 || !ok2 || {sdo_valid, busy, done, err} !== 4'b0) $display("FAIL rst_mid flags: ok %b%b got %b exp 0000", ok1, ok2, {sdo_valid, busy, done, err});
        else n_pass++;
        n_chk++;
        if (sdo_data !== '0 || word_idx !== '0) $display("FAIL rst_mid data_idx: got %h %0d exp 0 0", sdo_data, word_idx);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || vq_data.size() != 1) $display("FAIL rst_mid idle: busy %b valids %0d exp 0 1", busy, vq_data.size());
        else n_pass++;
        test_stream(3, "after_rst");
    endtask

`ifdef SPI_SEQ_TIMEOUT_EN
    task automatic test_watchdog();
        int t, c;
        bit ok;
        eng_en = 1'b0;
        start_seq(1, t);
        wait_idle(400, ok);
        c = cyc;
        n_chk++;
        if (!ok || c != t + 3 + TO) $display("FAIL wd_cycle: ok %b got %0d exp %0d", ok, c, t + 3 + TO);
        else n_pass++;
        n_chk++;
        if (err !== 1'b1) $display("FAIL wd_err: got %b exp 1", err);
        else n_pass++;
        repeat (3) @(negedge clk);
        eng_en = 1'b1;
        start_seq(1, t);
        n_chk++;
        if (err !== 1'b0) $display("FAIL wd_clear: got %b exp 0", err);
        else n_pass++;
        wait_idle(100, ok);
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_len_bounds();
        test_abort_mid();
        test_abort_gap();
        test_busy_lockout();
        test_reset_mid();
`ifdef SPI_SEQ_TIMEOUT_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_cfg_sequencer.md
# spi_cfg_sequencer

Register-configuration sequencer that sits directly upstream of the SPI shift engine in the sensor control path. A host loads up to NUM_WORDS command words into an internal table and issues `start_i`. The block then streams the words in order into the engine's SDO handshake (`sdo_data`/`sdo_valid`/`sdo_ready`), inserting a programmable inter-frame gap between words. It reports progress, completion and, optionally, a stalled-engine error.

## Interface
Parameters:
- DATA_WIDTH, 32, command word width; must match the SPI engine.
- NUM_WORDS, 16, table depth; power of two, ≥2.
- GAP_CYCLES, 4, idle cycles between the end of one frame and the next `sdo_valid_o`; 0 allowed.
- TIMEOUT_CYCLES, 255, watchdog limit per wait state; used only with SPI_SEQ_TIMEOUT_EN.

Ports:
- clk_i  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_wr_i  in  1  table write strobe.
- cfg_addr_i  in  $clog2(NUM_WORDS)  table write address.
- cfg_data_i  in  DATA_WIDTH  table write data.
- len_i  in  $clog2(NUM_WORDS)+1  number of words to send; sampled on start.
- start_i  in  1  single-cycle start pulse.
- abort_i  in  1  request to stop the sequence.
- sdo_data_o  out  DATA_WIDTH  word presented to the SPI engine.
- sdo_valid_o  out  1  one-cycle request to the engine.
- sdo_ready_i  in  1  engine busy-shifting flag: high for the whole frame, low otherwise.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse on normal completion.
- err_o  out  1  sticky watchdog error.
- word_idx_o  out  $clog2(NUM_WORDS)  index of the current or last word.

## Operation
- Reset values: sdo_data_o 0, sdo_valid_o 0, busy_o 0, done_o 0, err_o 0, word_idx_o 0. The FSM resets to IDLE. Table contents are not reset.
- Table writes are accepted only when busy_o=0. While busy_o=1 they are silently dropped.
- FSM states: IDLE, LOAD, REQ, WAIT_BUSY, WAIT_DONE, GAP, DONE, ERR.
- IDLE:
  - `start_i` latches len = min(len_i, NUM_WORDS), clears err_o and word_idx_o, and sets busy_o.
  - If len=0, go to DONE. Otherwise go to LOAD.
  - `start_i` while busy_o=1 is ignored.
- LOAD: read table[word_idx] into sdo_data_o, then go to REQ.
- REQ: sdo_valid_o=1 for exactly one cycle, then go to WAIT_BUSY. sdo_data_o holds stable from REQ until WAIT_DONE exits.
- WAIT_BUSY: wait for sdo_ready_i=1, then go to WAIT_DONE.
- WAIT_DONE: wait for sdo_ready_i=0. Then:
  - if word_idx == len-1, go to DONE;
  - otherwise increment word_idx and go to GAP.
- GAP: count GAP_CYCLES, then go to LOAD. With GAP_CYCLES=0, go straight to LOAD.
- DONE: pulse done_o for one cycle, clear busy_o, go to IDLE.
- abort_i handling:
  - In LOAD or GAP: go to IDLE immediately; busy_o clears, no done_o.
  - In REQ, WAIT_BUSY or WAIT_DONE: the abort is registered. The current frame always finishes (sdo_ready_i falls), then the FSM goes to IDLE, never cutting a frame.
  - In IDLE: ignored.
- Abort and last-word completion in the same cycle: abort wins, so no done_o.
- word_idx width equals $clog2(NUM_WORDS). The compare against len-1 uses the len width, so there is no wrap.

## Timing
- start_i at cycle T: LOAD at T+1, sdo_valid_o high at T+2.
- sdo_ready_i falling at cycle F:
  - next-word sdo_valid_o at F+2+GAP_CYCLES;
  - on the last word, done_o at F+1.
- busy_o is high from T+1 through the done_o cycle inclusive and is low the cycle after.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SPI_SEQ_TIMEOUT_EN defined:
  - a counter runs in WAIT_BUSY and WAIT_DONE and clears on state entry;
  - reaching TIMEOUT_CYCLES moves the FSM to ERR: err_o=1, sdo_valid_o=0, busy_o=0, word_idx_o frozen on the failing word;
  - ERR goes to IDLE the next cycle; err_o stays high until the next accepted start_i.
- SPI_SEQ_TIMEOUT_EN undefined: no counter, no ERR state; err_o is tied to 0 and waits are unbounded.

## Structure
- Package spi_cfg_pkg holds:
  - FSM state one-hot localparams, matching the engine's one-hot style;
  - default DATA_WIDTH, NUM_WORDS, GAP_CYCLES, TIMEOUT_CYCLES.
- Sub-module spi_cfg_table: NUM_WORDS×DATA_WIDTH register file with one synchronous write port and one registered read port. Read latency is 1 cycle, which is consumed in LOAD.
- The top level holds the FSM, gap/timeout counters, word index and abort latch.

## Test plan
- Basic stream: load 3 words 0xA5A5_0001/0002/0003 and start with len=3. The bench engine model raises sdo_ready_i 2 cycles after valid, for 33 cycles. Expect 3 valid pulses with the correct data in order, gaps of exactly GAP_CYCLES+2 cycles, and one done_o.
- len=0 and len=20 (NUM_WORDS=16): len=0 gives done_o at T+1 and no sdo_valid_o. len=20 is clamped and sends exactly 16 words.
- Mid-frame abort: abort_i during WAIT_DONE of word 1 of 4. Expect the frame to finish, IDLE one cycle after sdo_ready_i falls, no done_o, word_idx_o=1.
- Busy lockout: cfg_wr_i to addr 0 and start_i while busy_o=1. Expect table[0] unchanged and the sequence unaffected.
- Watchdog (SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=255): sdo_ready_i held low after REQ. Expect err_o=1 and busy_o=0 after 255 cycles. A new start clears err_o.
- Reset mid-sequence: rst_n low during GAP. Expect all outputs at their reset values immediately and the FSM in IDLE after release.
